maze_run_controller: RTL and testbench

- Sequencer that owns one mazeEscaper instance.
- On a start request it holds the escaper in reset for a fixed number of cycles, releases it, and supervises the run.
- During the run it counts clock cycles and moves, and ends the run on done, timeout or abort.
- It presents a result record to the host under a valid/ack handshake. It sits between the host/testbench control logic and the escaper.

---
 rtl/maze_pkg.sv | 25 ++
 rtl/maze_run_counter.sv | 47 ++++
 rtl/maze_run_controller.sv | 163 ++++++++++++++++
 tb/tb_maze_run_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze run controller and its escaper-side helpers.
package maze_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    TIMEOUT = 2'd2,
    ABORT   = 2'd3
  } run_status_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET_ESC = 2'd1,
    RUN       = 2'd2,
    RESULT    = 2'd3
  } ctrl_state_t;

  // Escaper move directions; NONE collides with run_status_t, hence the prefix.
  localparam logic [2:0] DIR_LEFT  = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_UP    = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

endpackage

// File: rtl/maze_run_counter.sv
// Saturating run-cycle and step counters; a step is any change of escaper position.
module maze_run_counter
  import maze_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [N-1:0]  esc_x,
  input  logic [N-1:0]  esc_y,
  output logic [CW-1:0] cyc_cnt,
  output logic [CW-1:0] step_cnt,
  output logic [CW-1:0] cyc_nxt_c,
  output logic [CW-1:0] step_nxt_c
);

  logic [2*N-1:0] prev_pos;
  logic [2*N-1:0] cur_pos;
  logic           moved;

  assign cur_pos = {esc_x, esc_y};
  assign moved   = (cur_pos != prev_pos);

  // Next values are exported so the exit cycle can be included in the result.
  assign cyc_nxt_c  = (&cyc_cnt) ? cyc_cnt : CW'(cyc_cnt + CW'(1));
  assign step_nxt_c = (moved && !(&step_cnt)) ? CW'(step_cnt + CW'(1)) : step_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      step_cnt <= '0;
      prev_pos <= '0;
    end else if (clear) begin
      cyc_cnt  <= '0;
      step_cnt <= '0;
      prev_pos <= cur_pos;
    end else if (enable) begin
      cyc_cnt  <= cyc_nxt_c;
      step_cnt <= step_nxt_c;
      if (moved) prev_pos <= cur_pos;
    end
  end

endmodule

// File: rtl/maze_run_controller.sv
// Sequences one escaper run: reset hold, supervised run, result handshake to the host.
module maze_run_controller
  import maze_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned CW         = 16,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] timeout_cycles,
  output logic          esc_rst,
  input  logic          esc_done,
  input  logic [N-1:0]  esc_x,
  input  logic [N-1:0]  esc_y,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ack,
  output logic [1:0]    status,
  output logic [CW-1:0] cycles,
  output logic [CW-1:0] steps,
  output logic [N-1:0]  end_x,
  output logic [N-1:0]  end_y
);

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ctrl_state_t   state, next_state;
  logic [CW-1:0] tlim, tlim_d;
  logic [RCW-1:0] rst_cnt, rst_cnt_d;
  logic          esc_rst_d, busy_d, result_valid_d;
  logic [1:0]    status_d;
  logic [CW-1:0] cycles_d, steps_d;
  logic [N-1:0]  end_x_d, end_y_d;

  logic [CW-1:0] cyc_cnt, step_cnt, cyc_nxt, step_nxt;
  logic          run_exit;
  logic [1:0]    exit_status;

  maze_run_counter #(.N(N), .CW(CW)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != RUN),
    .enable    (state == RUN),
    .esc_x     (esc_x),
    .esc_y     (esc_y),
    .cyc_cnt   (cyc_cnt),
    .step_cnt  (step_cnt),
    .cyc_nxt_c (cyc_nxt),
    .step_nxt_c(step_nxt)
  );

  // Exit priority: done over abort over timeout.
  always_comb begin
    run_exit    = 1'b1;
    exit_status = OK;
    if (esc_done) begin
      exit_status = OK;
    end else if (abort) begin
      exit_status = ABORT;
    end else if ((tlim != '0) && (cyc_nxt == tlim)) begin
      exit_status = TIMEOUT;
    end else begin
      run_exit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = RESET_ESC;
      RESET_ESC: begin
        if (abort)                next_state = RESULT;
        else if (rst_cnt == '0)   next_state = RUN;
      end
      RUN:       if (run_exit) next_state = RESULT;
      RESULT:    if (result_ack) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    tlim_d         = tlim;
    rst_cnt_d      = rst_cnt;
    result_valid_d = result_valid;
    status_d       = status;
    cycles_d       = cycles;
    steps_d        = steps;
    end_x_d        = end_x;
    end_y_d        = end_y;
    esc_rst_d      = (next_state != RUN);
    busy_d         = (next_state == RESET_ESC) || (next_state == RUN);
    case (state)
      IDLE: begin
        if (start) begin
          tlim_d    = timeout_cycles;
          rst_cnt_d = RCW'(RST_CYCLES - 1);
        end
      end
      RESET_ESC: begin
        if (abort) begin
          result_valid_d = 1'b1;
          status_d       = ABORT;
          cycles_d       = '0;
          steps_d        = '0;
          end_x_d        = '0;
          end_y_d        = '0;
        end else if (rst_cnt != '0) begin
          rst_cnt_d = RCW'(rst_cnt - 1'b1);
        end
      end
      RUN: begin
        if (run_exit) begin
          result_valid_d = 1'b1;
          status_d       = exit_status;
          cycles_d       = cyc_nxt;
          steps_d        = step_nxt;
          end_x_d        = esc_x;
          end_y_d        = esc_y;
        end
      end
      RESULT: begin
        if (result_ack) result_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlim         <= '0;
      rst_cnt      <= '0;
      esc_rst      <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      status       <= NONE;
      cycles       <= '0;
      steps        <= '0;
      end_x        <= '0;
      end_y        <= '0;
    end else begin
      tlim         <= tlim_d;
      rst_cnt      <= rst_cnt_d;
      esc_rst      <= esc_rst_d;
      busy         <= busy_d;
      result_valid <= result_valid_d;
      status       <= status_d;
      cycles       <= cycles_d;
      steps        <= steps_d;
      end_x        <= end_x_d;
      end_y        <= end_y_d;
    end
  end

endmodule

// File: tb/tb_maze_run_controller.sv
// Directed bench: scripted escaper path, vector table of runs, plus handshake/reset corners.
module tb_maze_run_controller;
  import maze_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, result_ack;
  logic [15:0] timeout_cycles;
  logic        esc_rst, esc_done, busy, result_valid;
  logic [2:0]  esc_x, esc_y, end_x, end_y;
  logic [1:0]  status;
  logic [15:0] cycles, steps;

  int n_vec  = 0;
  int n_miss = 0;

  maze_run_controller #(.N(3), .CW(16), .RST_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .timeout_cycles(timeout_cycles),
    .esc_rst       (esc_rst),
    .esc_done      (esc_done),
    .esc_x         (esc_x),
    .esc_y         (esc_y),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ack    (result_ack),
    .status        (status),
    .cycles        (cycles),
    .steps         (steps),
    .end_x         (end_x),
    .end_y         (end_y)
  );

  always #5 clk = ~clk;

  // Scripted escaper: one path index per run cycle, moves at idx 2,5,8,10, done at idx 11.
  logic [3:0] idx;
  always @(posedge clk) begin
    if (esc_rst)           idx <= 4'd0;
    else if (idx != 4'd11) idx <= idx + 4'd1;
  end

  always_comb begin
    esc_x = 3'd0;
    esc_y = 3'd0;
    case (idx)
      4'd2, 4'd3, 4'd4:  begin esc_x = 3'd1; esc_y = 3'd0; end
      4'd5, 4'd6, 4'd7:  begin esc_x = 3'd1; esc_y = 3'd1; end
      4'd8, 4'd9:        begin esc_x = 3'd2; esc_y = 3'd1; end
      4'd10, 4'd11:      begin esc_x = 3'd2; esc_y = 3'd2; end
      default:           begin esc_x = 3'd0; esc_y = 3'd0; end
    endcase
  end
  assign esc_done = (idx == 4'd11) && !esc_rst;

  typedef struct {
    logic [15:0] tlim;
    int          abort_at;
    logic [1:0]  st;
    logic [15:0] cyc;
    logic [15:0] stp;
    logic [2:0]  ex;
    logic [2:0]  ey;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, ".valid"},  32'(result_valid), 32'd1);
    chk({tag, ".status"}, 32'(status),       32'(v.st));
    chk({tag, ".cycles"}, 32'(cycles),       32'(v.cyc));
    chk({tag, ".steps"},  32'(steps),        32'(v.stp));
    chk({tag, ".end_x"},  32'(end_x),        32'(v.ex));
    chk({tag, ".end_y"},  32'(end_y),        32'(v.ey));
    chk({tag, ".esc_rst"}, 32'(esc_rst),     32'd1);
    chk({tag, ".busy"},   32'(busy),         32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit seen;
    @(negedge clk); timeout_cycles = v.tlim; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, ".busy_rc1"}, 32'(busy),    32'd1);
    chk({tag, ".rst_rc1"},  32'(esc_rst), 32'd1);
    @(negedge clk);
    chk({tag, ".rst_rc2"},  32'(esc_rst), 32'd1);
    @(negedge clk);
    chk({tag, ".rst_run"},  32'(esc_rst), 32'd0);
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      abort = (k == v.abort_at);
      @(negedge clk); abort = 1'b0;
      if (result_valid) seen = 1'b1;
    end
    chk({tag, ".exit_seen"}, 32'(seen), 32'd1);
    chk_result(tag, v);
  endtask

  task automatic ack_result(input string tag);
    @(negedge clk); result_ack = 1'b1;
    @(negedge clk); result_ack = 1'b0;
    chk({tag, ".ack_valid"}, 32'(result_valid), 32'd0);
  endtask

  vec_t zero_abort;
  vec_t ok_run;

  initial begin
    //           tlim   ab  status   cyc   stp   x     y
    vecs[0] = '{16'd0,  0,  OK,      16'd12, 16'd4, 3'd2, 3'd2};
    vecs[1] = '{16'd10, 0,  TIMEOUT, 16'd10, 16'd3, 3'd2, 3'd1};
    vecs[2] = '{16'd11, 0,  TIMEOUT, 16'd11, 16'd4, 3'd2, 3'd2};
    vecs[3] = '{16'd0,  5,  ABORT,   16'd5,  16'd1, 3'd1, 3'd0};
    vecs[4] = '{16'd0,  12, OK,      16'd12, 16'd4, 3'd2, 3'd2};
    vecs[5] = '{16'd12, 0,  OK,      16'd12, 16'd4, 3'd2, 3'd2};
    vecs[6] = '{16'd0,  1,  ABORT,   16'd1,  16'd0, 3'd0, 3'd0};
    vecs[7] = '{16'd1,  0,  TIMEOUT, 16'd1,  16'd0, 3'd0, 3'd0};
    zero_abort = '{16'd0, 0, ABORT, 16'd0, 16'd0, 3'd0, 3'd0};
    ok_run     = vecs[0];

    rst = 1'b1; start = 1'b0; abort = 1'b0; result_ack = 1'b0; timeout_cycles = '0;
    repeat (2) @(negedge clk);
    chk("reset.esc_rst", 32'(esc_rst),      32'd1);
    chk("reset.busy",    32'(busy),         32'd0);
    chk("reset.valid",   32'(result_valid), 32'd0);
    chk("reset.status",  32'(status),       32'd0);
    chk("reset.cycles",  32'(cycles),       32'd0);
    chk("reset.steps",   32'(steps),        32'd0);
    chk("reset.end_xy",  32'({end_x, end_y}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      ack_result($sformatf("v%0d", i));
    end

    // Abort while the escaper is still held in reset.
    @(negedge clk); timeout_cycles = '0; start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk_result("abort_rst", zero_abort);
    ack_result("abort_rst");

    // Result held with no ack; start pulses must be ignored.
    run_vec("hold", ok_run);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      chk($sformatf("hold%0d.valid", i),  32'(result_valid), 32'd1);
      chk($sformatf("hold%0d.cycles", i), 32'(cycles),       32'd12);
      chk($sformatf("hold%0d.busy", i),   32'(busy),         32'd0);
    end
    start = 1'b0;
    chk_result("hold_end", ok_run);

    // Ack together with start: back to IDLE, no run launched.
    @(negedge clk); result_ack = 1'b1; start = 1'b1;
    @(negedge clk); result_ack = 1'b0; start = 1'b0;
    chk("ackstart.valid", 32'(result_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("ackstart.busy",    32'(busy),    32'd0);
      chk("ackstart.esc_rst", 32'(esc_rst), 32'd1);
    end
    run_vec("after_ack", ok_run);
    ack_result("after_ack");

    // Asynchronous reset in the middle of a run.
    @(negedge clk); timeout_cycles = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun.esc_rst_pre", 32'(esc_rst), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrun.esc_rst", 32'(esc_rst),      32'd1);
    chk("midrun.busy",    32'(busy),         32'd0);
    chk("midrun.valid",   32'(result_valid), 32'd0);
    chk("midrun.status",  32'(status),       32'd0);
    chk("midrun.cycles",  32'(cycles),       32'd0);
    chk("midrun.steps",   32'(steps),        32'd0);
    chk("midrun.end_xy",  32'({end_x, end_y}), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_vec("post_rst", ok_run);
    ack_result("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
